// File: rtl/udma_crc_seq.sv
// Burst sequencer in front of the CRC-16 accumulator: seeds it at burst start,
// forwards bus words through one register stage, then latches and presents the result.
module udma_crc_seq (
  input  logic        CLK4,
  input  logic        RST,
  input  logic        BURST_START,
  input  logic        BURST_STOP,
  input  logic        WORD_VLD,
  input  logic [15:0] WORD_D,
  input  logic        CRC_OUT_ACK,
  input  logic [15:0] CRC_Q,
  output logic        CRC_ARM,
  output logic        CRC_ENB,
  output logic [15:0] CRC_D,
  output logic [15:0] CRC_OUT,
  output logic        CRC_OUT_VLD,
  output logic [15:0] WORD_CNT,
  output logic        BUSY,
  output logic        ERR_PROTO
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ACTIVE  = 3'd1,
    S_DRAIN   = 3'd2,
    S_LATCH   = 3'd3,
    S_PRESENT = 3'd4
  } state_t;

  state_t      state_q,    state_d;
  logic        arm_q,      arm_d;
  logic        enb_q,      enb_d;
  logic [15:0] crc_data_q, crc_data_d;
  logic [15:0] crc_out_q,  crc_out_d;
  logic        out_vld_q,  out_vld_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic        busy_q,     busy_d;
  logic        err_q,      err_d;

  always_ff @(posedge CLK4) begin
    if (RST) begin
      state_q    <= S_IDLE;
      arm_q      <= 1'b0;
      enb_q      <= 1'b0;
      crc_data_q <= 16'h0000;
      crc_out_q  <= 16'h0000;
      out_vld_q  <= 1'b0;
      word_cnt_q <= 16'h0000;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      arm_q      <= arm_d;
      enb_q      <= enb_d;
      crc_data_q <= crc_data_d;
      crc_out_q  <= crc_out_d;
      out_vld_q  <= out_vld_d;
      word_cnt_q <= word_cnt_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    arm_d      = arm_q;
    enb_d      = 1'b0;
    crc_data_d = crc_data_q;
    crc_out_d  = crc_out_q;
    out_vld_d  = out_vld_q;
    word_cnt_d = word_cnt_q;
    err_d      = err_q;

    case (state_q)
      S_IDLE: begin
        if (BURST_START) begin
          state_d    = S_ACTIVE;
          arm_d      = 1'b1;
          word_cnt_d = 16'h0000;
          err_d      = 1'b0;
        end
      end
      S_ACTIVE: begin
        if (WORD_VLD) begin
          crc_data_d = WORD_D;
          enb_d      = 1'b1;
          word_cnt_d = (word_cnt_q == 16'hFFFF) ? word_cnt_q : word_cnt_q + 16'd1;
        end
        if (BURST_STOP) begin
          state_d = S_DRAIN;
        end
      end
      // The last enable issued in ACTIVE lands in the accumulator during this cycle.
      S_DRAIN: begin
        state_d = S_LATCH;
      end
      S_LATCH: begin
        crc_out_d = CRC_Q;
        out_vld_d = 1'b1;
        state_d   = S_PRESENT;
      end
      S_PRESENT: begin
        if (CRC_OUT_ACK) begin
          state_d   = S_IDLE;
          out_vld_d = 1'b0;
          arm_d     = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Placed after the state logic so a stray word wins over the start-of-burst clear.
    if (WORD_VLD && (state_q != S_ACTIVE)) begin
      err_d = 1'b1;
    end

    busy_d = (state_d != S_IDLE);
  end

  assign CRC_ARM     = arm_q;
  assign CRC_ENB     = enb_q;
  assign CRC_D       = crc_data_q;
  assign CRC_OUT     = crc_out_q;
  assign CRC_OUT_VLD = out_vld_q;
  assign WORD_CNT    = word_cnt_q;
  assign BUSY        = busy_q;
  assign ERR_PROTO   = err_q;

endmodule

// File: tb/tb_udma_crc_seq.sv
// Bench for udma_crc_seq: a behavioural CRC accumulator closes the loop, and a
// scoreboard queue holds the expected CRC/count for each presented result.
module tb_udma_crc_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        burst_start, burst_stop, word_vld, crc_out_ack;
  logic [15:0] word_d;
  logic [15:0] acc = 16'h4ABA;
  logic        crc_arm, crc_enb, crc_out_vld, busy, err_proto;
  logic [15:0] crc_d, crc_out, word_cnt;

  typedef struct {
    logic [15:0] crc;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          checks_total = 0;
  int          checks_pass  = 0;
  int          enb_count    = 0;
  logic        prev_vld     = 1'b0;
  logic [15:0] last_cnt     = 16'h0000;

  always #5 clk = ~clk;

  udma_crc_seq dut (
    .CLK4        (clk),
    .RST         (rst),
    .BURST_START (burst_start),
    .BURST_STOP  (burst_stop),
    .WORD_VLD    (word_vld),
    .WORD_D      (word_d),
    .CRC_OUT_ACK (crc_out_ack),
    .CRC_Q       (acc),
    .CRC_ARM     (crc_arm),
    .CRC_ENB     (crc_enb),
    .CRC_D       (crc_d),
    .CRC_OUT     (crc_out),
    .CRC_OUT_VLD (crc_out_vld),
    .WORD_CNT    (word_cnt),
    .BUSY        (busy),
    .ERR_PROTO   (err_proto)
  );

  // Bit-serial CCITT polynomial, MSB of the data word first.
  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 15; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  // Downstream accumulator: held at seed while disarmed.
  always @(posedge clk) begin
    if (!crc_arm) acc <= 16'h4ABA;
    else if (crc_enb) acc <= crc_upd(acc, crc_d);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: pops one expectation on each rising edge of CRC_OUT_VLD.
  always @(negedge clk) begin
    exp_t e;
    if (crc_enb) enb_count++;
    if (crc_out_vld && !prev_vld) begin
      chk("sb_nonempty", {31'd0, sb_q.size() != 0}, 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("crc_out", {16'd0, crc_out}, {16'd0, e.crc});
        chk("word_cnt", {16'd0, word_cnt}, {16'd0, e.cnt});
        $display("result crc=0x%04h cnt=0x%04h (exp crc=0x%04h cnt=0x%04h)",
                 crc_out, word_cnt, e.crc, e.cnt);
      end
    end
    prev_vld = crc_out_vld;
  end

  task automatic run_burst(input int n, input bit gaps, input bit word_at_stop,
                           input bit start_word, input int ack_delay, input bit present_word);
    logic [15:0] exp_crc;
    logic [15:0] exp_cnt;
    int          cyc;
    bit          held;
    exp_t        e;
    burst_start = 1'b1;
    word_vld    = start_word;
    word_d      = 16'hDEAD;
    enb_count   = 0;
    @(negedge clk);
    burst_start = 1'b0;
    word_vld    = 1'b0;
    chk("err_after_start", {31'd0, err_proto}, {31'd0, start_word});
    exp_crc = 16'h4ABA;
    if (n == 0) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom_range(0, 2) == 0)) @(negedge clk);
      word_vld = 1'b1;
      word_d   = i[15:0];
      exp_crc  = crc_upd(exp_crc, word_d);
      if (word_at_stop && (i == n - 1)) burst_stop = 1'b1;
      @(negedge clk);
      word_vld   = 1'b0;
      burst_stop = 1'b0;
    end
    if (!(word_at_stop && n > 0)) begin
      burst_stop = 1'b1;
      @(negedge clk);
      burst_stop = 1'b0;
    end
    exp_cnt = (n > 65535) ? 16'hFFFF : n[15:0];
    e.crc = exp_crc;
    e.cnt = exp_cnt;
    sb_q.push_back(e);
    cyc = 1;
    while (!crc_out_vld && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    chk("vld_latency", cyc, 3);
    chk("enb_cycles", enb_count, n);
    held = 1'b1;
    for (int k = 0; k < ack_delay; k++) begin
      if (present_word && k == 0) word_vld = 1'b1;
      @(negedge clk);
      word_vld = 1'b0;
      if (!crc_out_vld) held = 1'b0;
    end
    if (present_word) begin
      chk("err_present", {31'd0, err_proto}, 32'd1);
      chk("cnt_present", {16'd0, word_cnt}, {16'd0, exp_cnt});
    end
    if (ack_delay > 0) chk("vld_held", {31'd0, held}, 32'd1);
    crc_out_ack = 1'b1;
    @(negedge clk);
    crc_out_ack = 1'b0;
    chk("ack_busy", {31'd0, busy}, 32'd0);
    chk("ack_vld", {31'd0, crc_out_vld}, 32'd0);
    chk("ack_arm", {31'd0, crc_arm}, 32'd0);
    last_cnt = exp_cnt;
    $display("burst n=%0d done, exp crc=0x%04h cnt=0x%04h", n, exp_crc, exp_cnt);
  endtask

  initial begin
    int cyc;
    rst = 1'b1; burst_start = 1'b0; burst_stop = 1'b0; word_vld = 1'b0;
    word_d = 16'h0000; crc_out_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_arm", {31'd0, crc_arm}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_vld", {31'd0, crc_out_vld}, 32'd0);
    chk("rst_cnt", {16'd0, word_cnt}, 32'd0);
    chk("rst_err", {31'd0, err_proto}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Zero-word burst, then single-word burst with the word on the STOP cycle.
    run_burst(0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run_burst(1, 1'b0, 1'b1, 1'b0, 2, 1'b0);

    // Stray word in IDLE.
    word_vld = 1'b1; word_d = 16'h1234;
    @(negedge clk);
    word_vld = 1'b0;
    chk("err_idle", {31'd0, err_proto}, 32'd1);
    chk("cnt_idle", {16'd0, word_cnt}, {16'd0, last_cnt});
    chk("enb_idle", {31'd0, crc_enb}, 32'd0);

    // 256 words with gaps; START clears the error, a word in PRESENT sets it again.
    run_burst(256, 1'b1, 1'b0, 1'b0, 5, 1'b1);

    // START and WORD_VLD together: error set wins.
    run_burst(3, 1'b0, 1'b1, 1'b1, 1, 1'b0);

    // Reset after ten words.
    burst_start = 1'b1;
    @(negedge clk);
    burst_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      word_vld = 1'b1; word_d = 16'h00A0 + i[15:0];
      @(negedge clk);
    end
    word_vld = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_arm", {31'd0, crc_arm}, 32'd0);
    chk("mid_rst_enb", {31'd0, crc_enb}, 32'd0);
    chk("mid_rst_crc_d", {16'd0, crc_d}, 32'd0);
    chk("mid_rst_crc_out", {16'd0, crc_out}, 32'd0);
    chk("mid_rst_cnt", {16'd0, word_cnt}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_err", {31'd0, err_proto}, 32'd0);
    cyc = 0;
    while (acc != 16'h4ABA && cyc < 2) begin
      @(negedge clk);
      cyc++;
    end
    chk("mid_rst_reseed", {16'd0, acc}, 32'h4ABA);
    @(negedge clk);
    run_burst(1, 1'b0, 1'b1, 1'b0, 0, 1'b0);

    // Count saturation.
    run_burst(65537, 1'b0, 1'b0, 1'b0, 0, 1'b0);

    repeat (4) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", checks_pass, checks_total);
    $finish;
  end

endmodule
